// File: rtl/spi_txfifo_arbiter.sv
// Round-robin arbiter sharing the spi_fifo write port between two frame sources, plus flush sequencing.
// Optional burst lock: define SPI_ARB_BURST_LOCK_EN to hold each grant for BURST_LEN transfers.
module spi_txfifo_arbiter #(
    parameter int CFG_FRAME_SIZE = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int BURST_LEN      = 4
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      req0_valid,
    input  logic [CFG_FRAME_SIZE-1:0] req0_data,
    input  logic                      req0_flag,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [CFG_FRAME_SIZE-1:0] req1_data,
    input  logic                      req1_flag,
    output logic                      req1_ready,
    input  logic                      flush_req,
    output logic                      flush_done,
    input  logic [5:0]                fifo_count,
    output logic                      fifo_write,
    output logic [CFG_FRAME_SIZE-1:0] fifo_data,
    output logic                      fifo_flag,
    output logic                      fifo_rst,
    output logic [1:0]                grant
);
    // Handshake: a frame moves on a rising edge where reqN_valid & reqN_ready are both high;
    // ready never looks at the same source's valid, and a source may hold valid for any time.
    typedef enum logic [1:0] {IDLE, GRANT, FLUSH, FLUSH_DONE} state_t;

    state_t                    state, state_n;
    logic [1:0]                grant_n;
    logic                      last_grant, last_grant_n;
    logic [1:0]                valids;
    logic                      own, own_valid, other_valid, pick;
    logic                      space_ok, xfer;
    logic [CFG_FRAME_SIZE-1:0] xfer_data;
    logic                      xfer_flag;

    assign valids      = {req1_valid, req0_valid};
    assign own         = grant[1];
    assign own_valid   = valids[own];
    assign other_valid = valids[~own];
    assign pick        = valids[~last_grant] ? ~last_grant : last_grant;

    // The write launched last edge is not yet in fifo_count, so it counts as occupied.
    assign space_ok = ({1'b0, fifo_count} + {6'd0, fifo_write}) < 7'(FIFO_DEPTH);

    assign req0_ready = (state == GRANT) && grant[0] && space_ok && !flush_req;
    assign req1_ready = (state == GRANT) && grant[1] && space_ok && !flush_req;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign xfer_data  = grant[1] ? req1_data : req0_data;
    assign xfer_flag  = grant[1] ? req1_flag : req0_flag;

`ifdef SPI_ARB_BURST_LOCK_EN
    logic [4:0] burst_cnt, burst_cnt_n;
    logic       burst_last;
    assign burst_last = (burst_cnt == 5'(BURST_LEN - 1));
`endif

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        if (flush_req && state != FLUSH) begin
            state_n = FLUSH;
            grant_n = 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (|valids) begin
                        state_n      = GRANT;
                        grant_n      = pick ? 2'b10 : 2'b01;
                        last_grant_n = pick;
                    end
                end
                GRANT: begin
`ifdef SPI_ARB_BURST_LOCK_EN
                    if (!own_valid) begin
                        if (other_valid) begin
                            grant_n      = ~grant;
                            last_grant_n = ~own;
                        end else begin
                            state_n = IDLE;
                            grant_n = 2'b00;
                        end
                    end else if (xfer && burst_last && other_valid) begin
                        grant_n      = ~grant;
                        last_grant_n = ~own;
                    end
`else
                    if (xfer || !own_valid) begin
                        if (other_valid) begin
                            grant_n      = ~grant;
                            last_grant_n = ~own;
                        end else if (!own_valid) begin
                            state_n = IDLE;
                            grant_n = 2'b00;
                        end
                    end
`endif
                end
                FLUSH: begin
                    state_n = FLUSH_DONE;
                end
                FLUSH_DONE: begin
                    state_n = IDLE;
                    grant_n = 2'b00;
                end
            endcase
        end
    end

`ifdef SPI_ARB_BURST_LOCK_EN
    // A completed burst restarts the count even when the same source keeps the grant.
    always_comb begin
        burst_cnt_n = burst_cnt;
        if (state_n != GRANT || grant_n != grant || (xfer && burst_last)) begin
            burst_cnt_n = '0;
        end else if (xfer) begin
            burst_cnt_n = burst_cnt + 5'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_cnt_n;
        end
    end
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            fifo_write <= 1'b0;
            fifo_data  <= '0;
            fifo_flag  <= 1'b0;
            fifo_rst   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            fifo_write <= xfer;
            if (xfer) begin
                fifo_data <= xfer_data;
                fifo_flag <= xfer_flag;
            end
            fifo_rst   <= (state_n == FLUSH);
            flush_done <= (state_n == FLUSH_DONE);
        end
    end
endmodule

// File: tb/tb_spi_txfifo_arbiter.sv
// Bench for spi_txfifo_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_spi_txfifo_arbiter;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int BLEN  = 4;

    logic         pclk = 1'b0;
    logic         preset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_flag = 1'b0, req1_flag = 1'b0;
    logic         req0_ready, req1_ready;
    logic         flush_req = 1'b0;
    logic         flush_done;
    logic [5:0]   fifo_count = '0;
    logic         fifo_write;
    logic [W-1:0] fifo_data;
    logic         fifo_flag;
    logic         fifo_rst;
    logic [1:0]   grant;

    int n_vec = 0;
    int n_err = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   obs_q[$];
    logic [1:0]   grant_q[$];

    spi_txfifo_arbiter #(.CFG_FRAME_SIZE(W), .FIFO_DEPTH(DEPTH), .BURST_LEN(BLEN)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_flag(req0_flag), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_flag(req1_flag), .req1_ready(req1_ready),
        .flush_req(flush_req), .flush_done(flush_done), .fifo_count(fifo_count),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .fifo_flag(fifo_flag),
        .fifo_rst(fifo_rst), .grant(grant)
    );

    always #5 pclk = ~pclk;

    // Leaves the caller at the negedge that opens the first cycle after reset.
    task automatic do_reset();
        @(negedge pclk);
        preset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; flush_req = 1'b0; fifo_count = '0;
        req0_data = '0; req1_data = '0; req0_flag = 1'b0; req1_flag = 1'b0;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
    endtask

    // Source 0 sends 0x10+i (flag 1), source 1 sends 0x20+i (flag 0); writes and grants are logged.
    task automatic run_sources(input int n_cycles, input int lim0, input int lim1);
        int sent0 = 0;
        int sent1 = 0;
        obs_q.delete();
        grant_q.delete();
        for (int i = 0; i < n_cycles; i++) begin
            if (i > 0) @(negedge pclk);
            req0_valid = (sent0 < lim0); req0_data = 8'(16 + sent0); req0_flag = 1'b1;
            req1_valid = (sent1 < lim1); req1_data = 8'(32 + sent1); req1_flag = 1'b0;
            #1;
            if (fifo_write === 1'b1) obs_q.push_back({fifo_flag, fifo_data});
            grant_q.push_back(grant);
            if (req0_valid && req0_ready) sent0++;
            if (req1_valid && req1_ready) sent1++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge pclk);
        preset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'hFF; req0_flag = 1'b1;
        repeat (2) @(negedge pclk);
        #1;
        n_vec++;
        if ({grant, req0_ready, req1_ready, fifo_write, fifo_rst, flush_done} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got grant=%b rdy=%b%b wr=%b rst=%b done=%b, want all 0",
                     grant, req0_ready, req1_ready, fifo_write, fifo_rst, flush_done);
        end
        n_vec++;
        if ({fifo_flag, fifo_data} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_data: got flag=%b data=%h, want 0/00", fifo_flag, fifo_data);
        end
    endtask

    task automatic test_first_frame();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA5; req0_flag = 1'b1;
        #1;
        n_vec++;
        if ({grant, req0_ready} !== 3'b000) begin
            n_err++; $display("FAIL first_c1: got grant=%b rdy0=%b, want 00/0", grant, req0_ready);
        end
        @(negedge pclk); #1;
        n_vec++;
        if ({grant, req0_ready} !== 3'b011) begin
            n_err++; $display("FAIL first_c2: got grant=%b rdy0=%b, want 01/1", grant, req0_ready);
        end
        @(negedge pclk); req0_valid = 1'b0; #1;
        n_vec++;
        if ({fifo_write, fifo_flag, fifo_data} !== 10'h3A5) begin
            n_err++;
            $display("FAIL first_c3: got wr=%b flag=%b data=%h, want 1/1/a5", fifo_write, fifo_flag, fifo_data);
        end
        @(negedge pclk); #1;
        n_vec++;
        if ({grant, fifo_write} !== 3'b000) begin
            n_err++; $display("FAIL first_c4: got grant=%b wr=%b, want 00/0", grant, fifo_write);
        end
    endtask

`ifdef SPI_ARB_BURST_LOCK_EN
    task automatic test_burst();
        logic [W:0] e;
        int src;
        do_reset();
        run_sources(24, 8, 8);
        n_vec++;
        if (obs_q.size() != 16) begin
            n_err++; $display("FAIL burst_count: got %0d writes, want 16", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < 16; k++) begin
            src = (k / 4) % 2;
            e = {src == 0, 8'((src == 0 ? 16 : 32) + (k / 8) * 4 + k % 4)};
            n_vec++;
            if (obs_q[k] !== e) begin
                n_err++; $display("FAIL burst_data[%0d]: got %h, want %h", k, obs_q[k], e);
            end
            n_vec++;
            if (grant_q[1 + k] !== (src == 0 ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL burst_grant[%0d]: got %b, want src %0d", k, grant_q[1 + k], src);
            end
        end
        do_reset();
        run_sources(12, 2, 3);
        n_vec++;
        if (obs_q.size() != 5 || obs_q[0] !== 9'h110 || obs_q[1] !== 9'h111 || obs_q[2] !== 9'h020
            || obs_q[3] !== 9'h021 || obs_q[4] !== 9'h022) begin
            n_err++; $display("FAIL burst_drop_data: got %0d writes %p, want 110 111 020 021 022", obs_q.size(), obs_q);
        end
        n_vec++;
        if (grant_q[3] !== 2'b01 || grant_q[4] !== 2'b10) begin
            n_err++; $display("FAIL burst_drop_grant: got %b,%b, want 01,10", grant_q[3], grant_q[4]);
        end
    endtask
`else
    task automatic test_alternate();
        logic [W:0] e;
        do_reset();
        run_sources(14, 5, 5);
        n_vec++;
        if (obs_q.size() != 10 || grant_q[0] !== 2'b00) begin
            n_err++; $display("FAIL alt_count: got %0d writes, grant0=%b, want 10/00", obs_q.size(), grant_q[0]);
        end
        for (int k = 0; k < obs_q.size() && k < 10; k++) begin
            e = (k % 2 == 0) ? {1'b1, 8'(16 + k / 2)} : {1'b0, 8'(32 + k / 2)};
            n_vec++;
            if (obs_q[k] !== e) begin
                n_err++; $display("FAIL alt_data[%0d]: got %h, want %h", k, obs_q[k], e);
            end
            n_vec++;
            if (grant_q[1 + k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL alt_grant[%0d]: got %b", k, grant_q[1 + k]);
            end
        end
    endtask
`endif

    task automatic test_full();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h31; fifo_count = 6'd7;
        @(negedge pclk); #1;
        n_vec++;
        if ({grant, req0_ready} !== 3'b011) begin
            n_err++; $display("FAIL full_c2: got grant=%b rdy0=%b, want 01/1", grant, req0_ready);
        end
        @(negedge pclk); req0_data = 8'h32; req1_valid = 1'b1; #1;
        n_vec++;
        if ({fifo_write, fifo_data, req0_ready, req1_ready} !== {1'b1, 8'h31, 2'b00}) begin
            n_err++;
            $display("FAIL full_inflight: got wr=%b data=%h rdy=%b%b, want 1/31/00",
                     fifo_write, fifo_data, req0_ready, req1_ready);
        end
        fifo_count = 6'd8;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk); #1;
            n_vec++;
            if ({grant, fifo_write, req0_ready, req1_ready} !== 5'b01000) begin
                n_err++;
                $display("FAIL full_stall[%0d]: got grant=%b wr=%b rdy=%b%b, want 01/0/00",
                         c, grant, fifo_write, req0_ready, req1_ready);
            end
        end
        fifo_count = 6'd6;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++; $display("FAIL full_resume: got rdy0=%b, want 1", req0_ready);
        end
        @(negedge pclk); req0_valid = 1'b0; req1_valid = 1'b0; #1;
        n_vec++;
        if ({grant, fifo_write, fifo_data, req1_ready} !== {2'b10, 1'b1, 8'h32, 1'b1}) begin
            n_err++;
            $display("FAIL full_after: got grant=%b wr=%b data=%h rdy1=%b, want 10/1/32/1",
                     grant, fifo_write, fifo_data, req1_ready);
        end
    endtask

    task automatic test_flush();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h40; req0_flag = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h50; req1_flag = 1'b1;
        @(negedge pclk); flush_req = 1'b1; #1;
        n_vec++;
        if ({grant, req0_ready, req1_ready} !== 4'b0100) begin
            n_err++; $display("FAIL flush_edge: got grant=%b rdy=%b%b, want 01/00", grant, req0_ready, req1_ready);
        end
        @(negedge pclk); flush_req = 1'b0; #1;
        n_vec++;
        if ({fifo_rst, flush_done, fifo_write} !== 3'b100) begin
            n_err++; $display("FAIL flush_rst: got rst=%b done=%b wr=%b, want 1/0/0", fifo_rst, flush_done, fifo_write);
        end
        @(negedge pclk); #1;
        n_vec++;
        if ({fifo_rst, flush_done, req0_ready, req1_ready} !== 4'b0100) begin
            n_err++;
            $display("FAIL flush_done: got rst=%b done=%b rdy=%b%b, want 0/1/00",
                     fifo_rst, flush_done, req0_ready, req1_ready);
        end
        @(negedge pclk); #1;
        n_vec++;
        if ({grant, flush_done, fifo_rst} !== 4'b0000) begin
            n_err++; $display("FAIL flush_idle: got grant=%b done=%b rst=%b, want 00/0/0", grant, flush_done, fifo_rst);
        end
        @(negedge pclk); #1;
        n_vec++;
        if (grant !== 2'b10) begin
            n_err++; $display("FAIL flush_resume: got grant=%b, want 10", grant);
        end
        @(negedge pclk); req0_valid = 1'b0; req1_valid = 1'b0; #1;
        n_vec++;
        if ({fifo_write, fifo_flag, fifo_data} !== 10'h350) begin
            n_err++; $display("FAIL flush_first_write: got wr=%b flag=%b data=%h, want 1/1/50", fifo_write, fifo_flag, fifo_data);
        end
    endtask

    task automatic test_preset();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h66; req0_flag = 1'b1;
        @(negedge pclk);
        @(negedge pclk); req1_valid = 1'b1; #1;
        n_vec++;
        if ({fifo_write, fifo_data} !== 9'h166) begin
            n_err++; $display("FAIL preset_pre: got wr=%b data=%h, want 1/66", fifo_write, fifo_data);
        end
        preset = 1'b1;
        @(negedge pclk); #1;
        n_vec++;
        if ({grant, req0_ready, req1_ready, fifo_write, fifo_rst, flush_done, fifo_flag, fifo_data} !== 16'h0) begin
            n_err++;
            $display("FAIL preset_mid: got grant=%b rdy=%b%b wr=%b rst=%b done=%b flag=%b data=%h, want all 0",
                     grant, req0_ready, req1_ready, fifo_write, fifo_rst, flush_done, fifo_flag, fifo_data);
        end
        preset = 1'b0;
        @(negedge pclk); #1;
        n_vec++;
        if (grant !== 2'b01) begin
            n_err++; $display("FAIL preset_regrant: got grant=%b, want 01", grant);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Model state: st 0=idle 1=granted 2=flush 3=flush done; owner/last are source numbers.
    task automatic test_random(input int n_cycles);
        int st, owner, last, bcnt, cnt, pop_pct, pref;
        bit m_fw, m_rst, m_done;
        bit v0, v1, fl, r0, r1, x0, x1, mine, other, pop;
        logic [1:0] eg, dg;
        logic [W:0] e;
        do_reset();
        st = 0; owner = 0; last = 1; bcnt = 0; cnt = 0;
        m_fw = 1'b0; m_rst = 1'b0; m_done = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n_cycles; i++) begin
            if (i > 0) @(negedge pclk);
            v0 = (i < n_cycles - 3) && ($urandom_range(0, 3) != 0);
            v1 = (i < n_cycles - 3) && ($urandom_range(0, 3) != 0);
            fl = (i < n_cycles - 3) && ($urandom_range(0, 39) == 0);
            req0_valid = v0; req0_data = 8'($urandom); req0_flag = 1'($urandom_range(0, 1));
            req1_valid = v1; req1_data = 8'($urandom); req1_flag = 1'($urandom_range(0, 1));
            flush_req = fl; fifo_count = 6'(cnt);
            #1;
            r0 = (st == 1) && (owner == 0) && (cnt + int'(m_fw) < DEPTH) && !fl;
            r1 = (st == 1) && (owner == 1) && (cnt + int'(m_fw) < DEPTH) && !fl;
            eg = (st == 1) ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00;
            dg = (st >= 2) ? 2'b00 : grant;
            n_vec++;
            if ({dg, req0_ready, req1_ready, fifo_write, fifo_rst, flush_done} !== {eg, r0, r1, m_fw, m_rst, m_done}) begin
                n_err++;
                $display("FAIL rnd_ctrl@%0d: got g=%b rdy=%b%b wr=%b rst=%b done=%b, want g=%b rdy=%b%b wr=%b rst=%b done=%b",
                         i, dg, req0_ready, req1_ready, fifo_write, fifo_rst, flush_done,
                         eg, r0, r1, m_fw, m_rst, m_done);
            end
            if (fifo_write === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_data@%0d: got write %h, want no write", i, fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({fifo_flag, fifo_data} !== e) begin
                        n_err++; $display("FAIL rnd_data@%0d: got %h, want %h", i, {fifo_flag, fifo_data}, e);
                    end
                end
                n_vec++;
                if (cnt >= DEPTH) begin
                    n_err++; $display("FAIL rnd_overflow@%0d: got write at count %0d, want count < %0d", i, cnt, DEPTH);
                end
            end
            x0 = v0 && r0;
            x1 = v1 && r1;
            if (x0) exp_q.push_back({req0_flag, req0_data});
            if (x1) exp_q.push_back({req1_flag, req1_data});
            pop_pct = ((i / 100) % 2 == 1) ? 70 : 10;
            pop = (cnt > 0) && ($urandom_range(0, 99) < pop_pct);
            if (m_rst) cnt = 0;
            else cnt = cnt + int'(m_fw) - int'(pop);
            m_fw = x0 || x1;
            mine  = (owner == 1) ? v1 : v0;
            other = (owner == 1) ? v0 : v1;
            if (fl && st != 2) begin
                st = 2;
            end else if (st == 0) begin
                if (v0 || v1) begin
                    pref = 1 - last;
                    owner = ((pref == 0) ? v0 : v1) ? pref : last;
                    last = owner; bcnt = 0; st = 1;
                end
            end else if (st == 1) begin
`ifdef SPI_ARB_BURST_LOCK_EN
                if (!mine) begin
                    if (other) begin owner = 1 - owner; last = owner; bcnt = 0; end
                    else st = 0;
                end else if (x0 || x1) begin
                    bcnt++;
                    if (bcnt == BLEN) begin
                        bcnt = 0;
                        if (other) begin owner = 1 - owner; last = owner; end
                    end
                end
`else
                if (x0 || x1 || !mine) begin
                    if (other) begin owner = 1 - owner; last = owner; end
                    else if (!mine) st = 0;
                end
`endif
            end else if (st == 2) begin
                st = 3;
            end else begin
                st = 0;
            end
            m_rst  = (st == 2);
            m_done = (st == 3);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rnd_drain: got %0d frames never written, want 0", exp_q.size());
        end
        req0_valid = 1'b0; req1_valid = 1'b0; flush_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
`ifdef SPI_ARB_BURST_LOCK_EN
        test_burst();
`else
        test_alternate();
`endif
        test_full();
        test_flush();
        test_preset();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
